stage_sequencer: RTL and testbench
==================================

// Module: stage_sequencer
// PURPOSE
//  Multi-cycle stage FSM of the TinyCPU core; sole driver of the `stage` bus consumed by the per-stage controls (issue register, regfile, ALU, memory).
//  Walks FETCH -> REG_READ -> EXECUTE -> MEM -> WRITEBACK, stalling on memory handshakes.
//  Also counts retired instructions, latches halt and flags memory timeouts.
// PARAMETERS
//  CNT_WIDTH       32   width of retired-instruction counter (wraps)
//  STALL_TIMEOUT   255  max consecutive stall cycles in one stage before timeout_err; 0 = check disabled
// PORTS
//  clk             in   1                   core clock, rising edge
//  rst             in   1                   asynchronous, active-high reset
//  imem_ready      in   1                   instruction memory returns word this cycle (FETCH handshake)
//  dmem_ready      in   1                   data access completes this cycle (MEM handshake)
//  is_mem_instr    in   1                   decoded instr is load/store; valid from REG_READ on
//  halt_req        in   1                   decoded instr is HALT; valid from REG_READ on
//  stage           out  $clog2(`NUM_STAGES) current stage encoding
//  stage_advance   out  1                   1 in last cycle of current stage (stage changes next edge)
//  retire          out  1                   1-cycle pulse when WRITEBACK completes
//  instr_count     out  CNT_WIDTH           retired-instruction count
//  halted          out  1                   sticky; core stopped
//  timeout_err     out  1                   sticky; stall exceeded STALL_TIMEOUT
// BEHAVIOUR
//  Reset (async, rst=1): stage=`STAGE_INSTR_FETCH, instr_count=0, halted=0, timeout_err=0, stall counter=0.
//   stage_advance/retire are combinational from state and are 0 while rst=1.
//  Transitions, evaluated each rising edge, only if !halted && !timeout_err:
//   FETCH:     advance iff imem_ready, else hold (stall)
//   REG_READ:  always advance after 1 cycle
//   EXECUTE:   always advance after 1 cycle
//   MEM:       advance iff dmem_ready || !is_mem_instr
//   WRITEBACK: 1 cycle -> FETCH; retire=1; instr_count += 1 (mod 2^CNT_WIDTH)
//  Minimum latency: 5 cycles per instruction with zero-wait memory.
//  Halt: if halt_req=1 in the WRITEBACK cycle, the instr still retires (count increments).
//   Next edge: halted=1, stage held at `STAGE_WRITEBACK. FETCH is never re-entered until reset.
//  Stall counter: counts consecutive held cycles in FETCH/MEM; clears on any advance.
//   If STALL_TIMEOUT!=0 and counter reaches STALL_TIMEOUT: timeout_err=1, stage frozen; only rst clears.
//  While halted or timeout_err: stage_advance=0, retire=0, all inputs ignored.
//  Simultaneous: imem_ready/dmem_ready outside their stage are ignored.
//   Counter wrap at all-ones -> 0 raises no flag.
//  rst mid-stall or mid-instruction: immediate return to FETCH; the in-flight instr is not counted.
// CONFIGURATION
//  STAGE_SEQ_SKIP_MEM_EN defined: EXECUTE goes straight to WRITEBACK when !is_mem_instr.
//   Non-memory instrs take 4 cycles. stage never shows `STAGE_MEM for them.
//  Undefined: MEM always visited. Non-memory instrs spend exactly 1 cycle there.
// STRUCTURE
//  arch_defines.v (shared include): `NUM_STAGES, `STAGE_INSTR_FETCH, `STAGE_REG_READ, `STAGE_EXECUTE, `STAGE_MEM, `STAGE_WRITEBACK.
//   Encodings are owned there; this block never uses literal stage numbers.
//  One sub-module: stall_timer (counter + STALL_TIMEOUT compare, clear/enable inputs, expired output).
//   FSM, retire counter and halt latch stay inline.
// TESTING
//  1 rst pulse mid-EXECUTE -> stage=FETCH, instr_count=0 on same cycle (async), no retire.
//  2 imem_ready, dmem_ready tied 1, is_mem_instr=0, 3 instrs -> retire every 5th cycle; instr_count=3 after 15 cycles
//    (every 4th cycle with STAGE_SEQ_SKIP_MEM_EN).
//  3 is_mem_instr=1, dmem_ready low 3 cycles -> MEM lasts 4 cycles; stage_advance=1 only on the dmem_ready cycle.
//  4 halt_req=1 through WRITEBACK -> retire pulse, count+1, halted=1.
//    stage stays `STAGE_WRITEBACK for 20 further cycles despite imem_ready=1.
//  5 STALL_TIMEOUT=4, imem_ready=0 -> timeout_err=1 after 4 FETCH stall cycles; stage frozen at FETCH; cleared only by rst.
//  6 CNT_WIDTH=4, 16 retirements -> instr_count wraps 15 -> 0; no error flag raised.

Source files
------------

// File: rtl/stage_sequencer_pkg.sv
// Shared stage encodings and types for the TinyCPU stage sequencer.
// The `STAGE_* macros own the encodings; the package re-exports them as typed constants.
`ifndef ARCH_DEFINES_SV
`define ARCH_DEFINES_SV
`define NUM_STAGES        5
`define STAGE_INSTR_FETCH 3'd0
`define STAGE_REG_READ    3'd1
`define STAGE_EXECUTE     3'd2
`define STAGE_MEM         3'd3
`define STAGE_WRITEBACK   3'd4
`endif

package stage_sequencer_pkg;
  localparam int STAGE_W = $clog2(`NUM_STAGES);

  typedef logic [STAGE_W-1:0] stage_t;

  localparam logic [STAGE_W-1:0] ST_FETCH     = `STAGE_INSTR_FETCH;
  localparam logic [STAGE_W-1:0] ST_REG_READ  = `STAGE_REG_READ;
  localparam logic [STAGE_W-1:0] ST_EXECUTE   = `STAGE_EXECUTE;
  localparam logic [STAGE_W-1:0] ST_MEM       = `STAGE_MEM;
  localparam logic [STAGE_W-1:0] ST_WRITEBACK = `STAGE_WRITEBACK;
endpackage

// File: rtl/stage_sequencer_stall_timer.sv
// Consecutive-stall counter; expired fires on the held cycle that brings the count to TIMEOUT.
// TIMEOUT = 0 disables the check entirely.
module stall_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 2);

  logic [W-1:0] count;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign expired = 1'b0;
    end else begin : g_enabled
      assign expired = enable && (count == W'(TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage FSM of the TinyCPU core: stage walk, retire counter, halt latch, stall timeout.
// Define STAGE_SEQ_SKIP_MEM_EN to let non-memory instructions bypass the MEM stage.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH     = 32,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 is_mem_instr,
  input  logic                 halt_req,
  output logic [STAGE_W-1:0]   stage,
  output logic                 stage_advance,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic                 halted,
  output logic                 timeout_err
);
  logic         run;
  logic         hold;
  logic         advance;
  logic         wb_done;
  logic         expired;
  stage_t       stage_next;

  assign run = !halted && !timeout_err;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stage_next = stage;
    hold       = 1'b0;
    case (stage)
      ST_FETCH:    if (imem_ready) stage_next = ST_REG_READ; else hold = 1'b1;
      ST_REG_READ: stage_next = ST_EXECUTE;
      ST_EXECUTE: begin
`ifdef STAGE_SEQ_SKIP_MEM_EN
        stage_next = is_mem_instr ? ST_MEM : ST_WRITEBACK;
`else
        stage_next = ST_MEM;
`endif
      end
      ST_MEM:      if (dmem_ready || !is_mem_instr) stage_next = ST_WRITEBACK; else hold = 1'b1;
      // A halting instruction retires but parks the core in WRITEBACK.
      ST_WRITEBACK: if (!halt_req) stage_next = ST_FETCH;
      default:     stage_next = ST_FETCH;
    endcase
    if (!run) begin
      stage_next = stage;
      hold       = 1'b0;
    end
  end

  assign advance       = run && (stage_next != stage);
  assign wb_done       = run && (stage == ST_WRITEBACK);
  assign stage_advance = advance && !rst;
  assign retire        = wb_done && !rst;

  stall_timer #(
    .TIMEOUT (STALL_TIMEOUT)
  ) u_stall_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (advance),
    .enable  (hold),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage       <= ST_FETCH;
      instr_count <= '0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      stage <= stage_next;
      if (expired) timeout_err <= 1'b1;
      if (wb_done) begin
        instr_count <= instr_count + CNT_WIDTH'(1);
        if (halt_req) halted <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench: two sequencer instances (default and CNT_WIDTH=4/STALL_TIMEOUT=4)
// compared every cycle against a phase-index reference model, plus directed literal checks.
module tb_stage_sequencer;
  import stage_sequencer_pkg::*;

`ifdef STAGE_SEQ_SKIP_MEM_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int LAT = SKIP ? 4 : 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0, is_mem_instr = 1'b0, halt_req = 1'b0;

  logic [STAGE_W-1:0] a_stage, b_stage;
  logic               a_adv, b_adv, a_ret, b_ret, a_halt, b_halt, a_err, b_err;
  logic [31:0]        a_count;
  logic [3:0]         b_count;

  int  errors = 0;
  int  checks = 0;
  bit  cmp_on = 1'b0;

  always #5 clk = ~clk;

  stage_sequencer dut_a (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .is_mem_instr(is_mem_instr), .halt_req(halt_req), .stage(a_stage),
    .stage_advance(a_adv), .retire(a_ret), .instr_count(a_count),
    .halted(a_halt), .timeout_err(a_err)
  );

  stage_sequencer #(.CNT_WIDTH(4), .STALL_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .is_mem_instr(is_mem_instr), .halt_req(halt_req), .stage(b_stage),
    .stage_advance(b_adv), .retire(b_ret), .instr_count(b_count),
    .halted(b_halt), .timeout_err(b_err)
  );

  // Reference model: phase 0..4 = FETCH, REG_READ, EXECUTE, MEM, WRITEBACK.
  int              ph  [2];
  longint unsigned cnt [2];
  bit              hlt [2];
  bit              err [2];
  int              stl [2];

  function automatic int tmo(int k);
    return (k == 1) ? 4 : 255;
  endfunction

  function automatic logic [STAGE_W-1:0] code(int p);
    logic [STAGE_W-1:0] c;
    case (p)
      0:       c = ST_FETCH;
      1:       c = ST_REG_READ;
      2:       c = ST_EXECUTE;
      3:       c = ST_MEM;
      default: c = ST_WRITEBACK;
    endcase
    return c;
  endfunction

  function automatic bit would_adv(int k);
    case (ph[k])
      0:       return imem_ready;
      1, 2:    return 1'b1;
      3:       return dmem_ready || !is_mem_instr;
      default: return !halt_req;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        ph[k] <= 0; cnt[k] <= 0; hlt[k] <= 1'b0; err[k] <= 1'b0; stl[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!hlt[k] && !err[k]) begin
          if (would_adv(k)) begin
            stl[k] <= 0;
            case (ph[k])
              0: ph[k] <= 1;
              1: ph[k] <= 2;
              2: ph[k] <= (SKIP && !is_mem_instr) ? 4 : 3;
              3: ph[k] <= 4;
              default: begin ph[k] <= 0; cnt[k] <= cnt[k] + 1; end
            endcase
          end else if (ph[k] == 4) begin
            cnt[k] <= cnt[k] + 1;
            hlt[k] <= 1'b1;
          end else begin
            stl[k] <= stl[k] + 1;
            if (stl[k] + 1 == tmo(k)) err[k] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        string   n;
        bit      live;
        n    = (k == 0) ? "a" : "b";
        live = !rst && !hlt[k] && !err[k];
        check({n, " stage"}, (k == 0) ? 64'(a_stage) : 64'(b_stage), 64'(code(ph[k])));
        check({n, " stage_advance"}, (k == 0) ? 64'(a_adv) : 64'(b_adv), 64'(live && would_adv(k)));
        check({n, " retire"}, (k == 0) ? 64'(a_ret) : 64'(b_ret), 64'(live && ph[k] == 4));
        check({n, " instr_count"}, (k == 0) ? 64'(a_count) : 64'(b_count),
              (k == 0) ? (cnt[k] & 64'hFFFF_FFFF) : (cnt[k] & 64'hF));
        check({n, " halted"}, (k == 0) ? 64'(a_halt) : 64'(b_halt), 64'(hlt[k]));
        check({n, " timeout_err"}, (k == 0) ? 64'(a_err) : 64'(b_err), 64'(err[k]));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_in(input logic im, input logic dm, input logic mi, input logic hr);
    imem_ready = im; dmem_ready = dm; is_mem_instr = mi; halt_req = hr;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    // Reset state; stage_advance must stay low while rst is held even with imem_ready=1.
    set_in(1, 1, 0, 0);
    rst = 1'b1;
    #2;
    check("rst stage_advance gated", 64'(a_adv), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cmp_on = 1'b1;
    check("reset stage", 64'(a_stage), 64'(ST_FETCH));
    check("reset count", 64'(a_count), 64'd0);

    // Zero-wait non-memory stream: one retirement every LAT cycles.
    tick(3 * LAT);
    check("zero-wait a count=3", 64'(a_count), 64'd3);
    check("zero-wait b count=3", 64'(b_count), 64'd3);

    // Async reset mid-EXECUTE: FETCH and count 0 before any clock edge.
    tick(2);
    check("mid-exec stage", 64'(a_stage), 64'(ST_EXECUTE));
    #2;
    rst = 1'b1;
    #1;
    check("async rst stage", 64'(a_stage), 64'(ST_FETCH));
    check("async rst count", 64'(a_count), 64'd0);
    check("async rst retire", 64'(a_ret), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // MEM stall: dmem_ready low for 3 cycles, advance only on the ready cycle.
    set_in(1, 0, 1, 0);
    do_reset();
    tick(3);
    check("mem entered", 64'(a_stage), 64'(ST_MEM));
    tick(3);
    check("mem still held", 64'(a_stage), 64'(ST_MEM));
    check("mem no advance", 64'(a_adv), 64'd0);
    dmem_ready = 1'b1;
    #1;
    check("mem advance on ready", 64'(a_adv), 64'd1);
    tick(1);
    check("mem -> writeback", 64'(a_stage), 64'(ST_WRITEBACK));

    // Halt in WRITEBACK: retires, then parks for good.
    set_in(1, 1, 0, 1);
    do_reset();
    tick(LAT - 1);
    check("halt wb retire", 64'(a_ret), 64'd1);
    tick(1);
    check("halted set", 64'(a_halt), 64'd1);
    check("halt count", 64'(a_count), 64'd1);
    tick(20);
    check("halt parked stage", 64'(a_stage), 64'(ST_WRITEBACK));
    check("halt parked count", 64'(a_count), 64'd1);

    // FETCH stall timeout on the STALL_TIMEOUT=4 instance.
    set_in(0, 1, 0, 0);
    do_reset();
    tick(3);
    check("b no timeout after 3", 64'(b_err), 64'd0);
    tick(1);
    check("b timeout after 4", 64'(b_err), 64'd1);
    check("a no timeout", 64'(a_err), 64'd0);
    imem_ready = 1'b1;
    tick(2);
    check("b frozen at fetch", 64'(b_stage), 64'(ST_FETCH));
    check("a runs on", 64'(a_stage), 64'(ST_EXECUTE));

    // Default-timeout instance: 255 consecutive FETCH stalls.
    set_in(0, 1, 0, 0);
    do_reset();
    tick(254);
    check("a no timeout at 254", 64'(a_err), 64'd0);
    tick(1);
    check("a timeout at 255", 64'(a_err), 64'd1);

    // Counter wrap on the 4-bit instance.
    set_in(1, 1, 0, 0);
    do_reset();
    tick(15 * LAT);
    check("b count 15", 64'(b_count), 64'd15);
    tick(LAT);
    check("b count wraps", 64'(b_count), 64'd0);
    check("b no flag on wrap", 64'(b_err), 64'd0);
    check("a count 16", 64'(a_count), 64'd16);

    // Randomized traffic with occasional resets, checked every cycle by the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      imem_ready   = ($urandom_range(0, 3) != 0);
      dmem_ready   = ($urandom_range(0, 1) != 0);
      is_mem_instr = ($urandom_range(0, 1) != 0);
      halt_req     = ($urandom_range(0, 39) == 0);
      tick(1);
    end

    cmp_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
